control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op, input, 6, opcode field from instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port state, output, 3, current FSM state.
REQ-006 SHALL have ports PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, output, 1 each, PC load, IR load, instruction fetch, data-memory read, data-memory write, register-file write.
REQ-007 SHALL have ports ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc, output, 1 each: shamt/rs select, imm/rt select, sign/zero extend, DB/PC+4 writeback, memory/ALU result.
REQ-008 SHALL have ports ALUOp, output, 3; RegDst, output, 2 (00 $31, 01 rt, 10 rd); PCSrc, output, 2 (00 PC+4, 01 branch, 10 jr, 11 jump), driving the next-PC mux.

Function
REQ-009 SHALL hold a 3-bit state register: IF=000, ID=001, EXE_BR=101, EXE_AL=110, WB_AL=111, EXE_LS=010, MEM=011, WB_LD=100; state output equals it.
REQ-010 SHALL decode opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
REQ-011 SHALL make all outputs combinational functions of state, op, zero; only state is registered.
REQ-012 SHALL transition IF -> ID unconditionally.
REQ-013 SHALL transition ID -> EXE_AL for add/sub/addi/or/and/ori/sll/slt; ID -> EXE_BR for beq/bne; ID -> EXE_LS for sw/lw; ID -> IF for j/jr/jal/halt/undefined.
REQ-014 SHALL transition EXE_AL -> WB_AL -> IF; EXE_BR -> IF; EXE_LS -> MEM; MEM -> IF for sw, MEM -> WB_LD for lw; WB_LD -> IF.
REQ-015 SHALL assert IRWre=1 and InsMemRW=1 only in IF.
REQ-016 SHALL assert PCWre=1 for exactly one cycle per instruction, in the final state before IF (ID for j/jr/jal/undefined, EXE_BR, WB_AL, MEM for sw, WB_LD); PCWre=0 for halt, so the same instruction refetches forever.
REQ-017 SHALL drive PCSrc: 11 for j/jal, 10 for jr, 01 in EXE_BR when (beq and zero) or (bne and not zero), else 00.
REQ-018 SHALL assert RegWre=1 only in WB_AL, WB_LD, and ID for jal; jal uses RegDst=00, WrRegDSrc=0.
REQ-019 SHALL use RegDst=10 for R-type (add/sub/or/and/sll/slt), 01 for addi/ori/lw, WrRegDSrc=1 outside jal.
REQ-020 SHALL assert mWR=1 only in MEM for sw, mRD=1 only in MEM for lw, DBDataSrc=1 only for lw.
REQ-021 SHALL set ALUSrcA=1 only for sll; ALUSrcB=1 for addi/ori/lw/sw; ExtSel=0 only for ori.
REQ-022 SHALL set ALUOp: 000 add/addi/lw/sw, 001 sub/beq/bne, 010 sll, 011 or/ori, 100 and, 110 slt; 000 otherwise.
REQ-023 SHALL hold all outputs not explicitly asserted at 0 (ALUOp 000, RegDst 00, PCSrc 00).
REQ-024 SHALL evaluate zero only in EXE_BR; zero changes elsewhere have no effect.

Reset
REQ-025 SHALL, while Reset=0, force state=IF immediately regardless of CLK, aborting any instruction mid-flight.
REQ-026 SHALL present IF outputs during reset: IRWre=1, InsMemRW=1, all others 0, PCSrc=00, ALUOp=000.
REQ-027 SHALL take the first transition (IF -> ID) on the first rising CLK edge after Reset deasserts.

Verification
REQ-028 add (op=000000): states 000,001,110,111,000; RegWre=1, RegDst=10, PCWre=1 only in 111.
REQ-029 lw (op=110001): states 000,001,010,011,100,000; mRD=1 in 011; RegWre=1, DBDataSrc=1, PCWre=1 in 100.
REQ-030 beq with zero=1 -> PCSrc=01, PCWre=1 in 101; bne with zero=1 -> PCSrc=00, PCWre=1.
REQ-031 jal (op=111010): ID gives PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1, next state 000.
REQ-032 halt (op=111111): states cycle 000,001,000,... with PCWre=0 every cycle.
REQ-033 Reset=0 asserted in MEM during sw: state=000 and mWR=0 before next CLK edge.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control unit: one registered state, with every control
// output decoded combinationally from state, opcode and the ALU zero flag.
module control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t     state_r;
  logic       is_rtype_s, is_alu_s, is_addi_s, is_ori_s, is_sll_s;
  logic       is_sw_s, is_lw_s, is_beq_s, is_bne_s;
  logic       is_j_s, is_jr_s, is_jal_s, is_halt_s;
  logic [2:0] alu_op_s;
  logic       br_taken_s;

  // Opcode decode into instruction classes and the ALU operation
  always_comb begin
    is_rtype_s = 1'b0; is_alu_s = 1'b0; is_addi_s = 1'b0; is_ori_s = 1'b0;
    is_sll_s = 1'b0; is_sw_s = 1'b0; is_lw_s = 1'b0; is_beq_s = 1'b0;
    is_bne_s = 1'b0; is_j_s = 1'b0; is_jr_s = 1'b0; is_jal_s = 1'b0;
    is_halt_s = 1'b0; alu_op_s = 3'b000;
    case (op)
      6'b000000: begin is_rtype_s = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b000; end
      6'b000001: begin is_rtype_s = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b001; end
      6'b000010: begin is_addi_s  = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b000; end
      6'b010000: begin is_rtype_s = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b011; end
      6'b010001: begin is_rtype_s = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b100; end
      6'b010010: begin is_ori_s   = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b011; end
      6'b011000: begin is_rtype_s = 1'b1; is_sll_s = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b010; end
      6'b100110: begin is_rtype_s = 1'b1; is_alu_s = 1'b1; alu_op_s = 3'b110; end
      6'b110000: begin is_sw_s  = 1'b1; alu_op_s = 3'b000; end
      6'b110001: begin is_lw_s  = 1'b1; alu_op_s = 3'b000; end
      6'b110100: begin is_beq_s = 1'b1; alu_op_s = 3'b001; end
      6'b110101: begin is_bne_s = 1'b1; alu_op_s = 3'b001; end
      6'b111000: is_j_s    = 1'b1;
      6'b111001: is_jr_s   = 1'b1;
      6'b111010: is_jal_s  = 1'b1;
      6'b111111: is_halt_s = 1'b1;
      default:   alu_op_s  = 3'b000;
    endcase
  end

  assign br_taken_s = (is_beq_s & zero) | (is_bne_s & ~zero);
  assign state      = state_r;

  // State register; reset aborts any instruction and returns to fetch
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IF;
    end else begin
      case (state_r)
        S_IF:     state_r <= S_ID;
        S_ID: begin
          if (is_alu_s)                  state_r <= S_EXE_AL;
          else if (is_beq_s || is_bne_s) state_r <= S_EXE_BR;
          else if (is_sw_s || is_lw_s)   state_r <= S_EXE_LS;
          else                           state_r <= S_IF;
        end
        S_EXE_AL: state_r <= S_WB_AL;
        S_WB_AL:  state_r <= S_IF;
        S_EXE_BR: state_r <= S_IF;
        S_EXE_LS: state_r <= S_MEM;
        S_MEM: begin
          if (is_lw_s) state_r <= S_WB_LD;
          else         state_r <= S_IF;
        end
        S_WB_LD:  state_r <= S_IF;
        default:  state_r <= S_IF;
      endcase
    end
  end

  // Control outputs; datapath selects are quiet during fetch
  always_comb begin
    PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; mRD = 1'b0; mWR = 1'b0;
    RegWre = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ExtSel = 1'b0;
    WrRegDSrc = 1'b0; DBDataSrc = 1'b0; ALUOp = 3'b000; RegDst = 2'b00;
    PCSrc = 2'b00;
    if (state_r == S_IF) begin
      IRWre    = 1'b1;
      InsMemRW = 1'b1;
    end else begin
      ALUSrcA   = is_sll_s;
      ALUSrcB   = is_addi_s | is_ori_s | is_lw_s | is_sw_s;
      ExtSel    = ~is_ori_s;
      WrRegDSrc = ~is_jal_s;
      DBDataSrc = is_lw_s;
      ALUOp     = alu_op_s;
      if (is_rtype_s)                        RegDst = 2'b10;
      else if (is_addi_s || is_ori_s || is_lw_s) RegDst = 2'b01;
      else                                   RegDst = 2'b00;
      case (state_r)
        S_ID: begin
          // Jumps and undefined opcodes retire here; halt never advances the PC
          PCWre  = ~(is_alu_s | is_beq_s | is_bne_s | is_sw_s | is_lw_s | is_halt_s);
          RegWre = is_jal_s;
          if (is_j_s || is_jal_s) PCSrc = 2'b11;
          else if (is_jr_s)       PCSrc = 2'b10;
          else                    PCSrc = 2'b00;
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = br_taken_s ? 2'b01 : 2'b00;
        end
        S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        S_MEM: begin
          PCWre = is_sw_s;
          mWR   = is_sw_s;
          mRD   = is_lw_s;
        end
        S_WB_LD: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: PCWre = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class through its
// state sequence and compares the full control word against hand-computed values.
module tb_control_unit;

  logic       CLK, Reset, zero;
  logic [5:0] op;
  logic [2:0] state, ALUOp;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic       ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc;
  logic [1:0] RegDst, PCSrc;

  int n_vec = 0;
  int n_err = 0;

  control_unit dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .ALUOp(ALUOp),
    .RegDst(RegDst), .PCSrc(PCSrc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control word: state | PCWre IRWre InsMemRW mRD mWR RegWre | ALUSrcA ALUSrcB ExtSel WrRegDSrc DBDataSrc | ALUOp | RegDst | PCSrc
  logic [20:0] outs;
  assign outs = {state, PCWre, IRWre, InsMemRW, mRD, mWR, RegWre,
                 ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc, ALUOp, RegDst, PCSrc};

  function automatic logic [20:0] v(input logic [2:0] s, input logic [5:0] ctl,
                                    input logic [4:0] dp, input logic [2:0] aop,
                                    input logic [1:0] rd, input logic [1:0] pcs);
    return {s, ctl, dp, aop, rd, pcs};
  endfunction

  task automatic check_vec(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  localparam logic [20:0] V_IF = {3'b000, 6'b011000, 5'b00000, 3'b000, 2'b00, 2'b00};

  initial begin
    Reset = 1'b0; op = 6'b000000; zero = 1'b0;
    #3 check_vec("reset_async", outs, V_IF);
    @(negedge CLK);
    check_vec("reset_held", outs, V_IF);
    Reset = 1'b1;

    // add
    check_vec("add_if", outs, V_IF);
    tick(); check_vec("add_id",  outs, v(3'b001, 6'b000000, 5'b00110, 3'b000, 2'b10, 2'b00));
    tick(); check_vec("add_exe", outs, v(3'b110, 6'b000000, 5'b00110, 3'b000, 2'b10, 2'b00));
    tick(); check_vec("add_wb",  outs, v(3'b111, 6'b100001, 5'b00110, 3'b000, 2'b10, 2'b00));
    tick(); check_vec("add_ret", outs, V_IF);

    // lw
    op = 6'b110001;
    tick(); check_vec("lw_id",  outs, v(3'b001, 6'b000000, 5'b01111, 3'b000, 2'b01, 2'b00));
    tick(); check_vec("lw_exe", outs, v(3'b010, 6'b000000, 5'b01111, 3'b000, 2'b01, 2'b00));
    tick(); check_vec("lw_mem", outs, v(3'b011, 6'b000100, 5'b01111, 3'b000, 2'b01, 2'b00));
    tick(); check_vec("lw_wb",  outs, v(3'b100, 6'b100001, 5'b01111, 3'b000, 2'b01, 2'b00));
    tick(); check_vec("lw_ret", outs, V_IF);

    // beq taken; zero is ignored while in ID
    op = 6'b110100; zero = 1'b1;
    tick(); check_vec("beq_id", outs, v(3'b001, 6'b000000, 5'b00110, 3'b001, 2'b00, 2'b00));
    tick(); check_vec("beq_z1", outs, v(3'b101, 6'b100000, 5'b00110, 3'b001, 2'b00, 2'b01));
    zero = 1'b0; #1;
    check_vec("beq_z0", outs, v(3'b101, 6'b100000, 5'b00110, 3'b001, 2'b00, 2'b00));
    tick(); check_vec("beq_ret", outs, V_IF);

    // bne not taken with zero=1, taken with zero=0
    op = 6'b110101; zero = 1'b1;
    tick(); tick();
    check_vec("bne_z1", outs, v(3'b101, 6'b100000, 5'b00110, 3'b001, 2'b00, 2'b00));
    zero = 1'b0; #1;
    check_vec("bne_z0", outs, v(3'b101, 6'b100000, 5'b00110, 3'b001, 2'b00, 2'b01));
    tick(); check_vec("bne_ret", outs, V_IF);

    // jal, j, jr, undefined all retire in ID
    op = 6'b111010;
    tick(); check_vec("jal_id",  outs, v(3'b001, 6'b100001, 5'b00100, 3'b000, 2'b00, 2'b11));
    tick(); check_vec("jal_ret", outs, V_IF);
    op = 6'b111000;
    tick(); check_vec("j_id",    outs, v(3'b001, 6'b100000, 5'b00110, 3'b000, 2'b00, 2'b11));
    tick(); check_vec("j_ret",   outs, V_IF);
    op = 6'b111001;
    tick(); check_vec("jr_id",   outs, v(3'b001, 6'b100000, 5'b00110, 3'b000, 2'b00, 2'b10));
    tick(); check_vec("jr_ret",  outs, V_IF);
    op = 6'b101010;
    tick(); check_vec("undef_id", outs, v(3'b001, 6'b100000, 5'b00110, 3'b000, 2'b00, 2'b00));
    tick(); check_vec("undef_ret", outs, V_IF);

    // halt refetches forever without loading the PC
    op = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      tick(); check_vec("halt_id", outs, v(3'b001, 6'b000000, 5'b00110, 3'b000, 2'b00, 2'b00));
      tick(); check_vec("halt_if", outs, V_IF);
    end

    // ALU variants, checked in EXE_AL
    op = 6'b010010;
    tick(); tick(); check_vec("ori_exe", outs, v(3'b110, 6'b000000, 5'b01010, 3'b011, 2'b01, 2'b00));
    tick(); tick();
    op = 6'b011000;
    tick(); tick(); check_vec("sll_exe", outs, v(3'b110, 6'b000000, 5'b10110, 3'b010, 2'b10, 2'b00));
    tick(); tick();
    op = 6'b010001;
    tick(); tick(); check_vec("and_exe", outs, v(3'b110, 6'b000000, 5'b00110, 3'b100, 2'b10, 2'b00));
    tick(); tick();
    op = 6'b100110;
    tick(); tick(); check_vec("slt_exe", outs, v(3'b110, 6'b000000, 5'b00110, 3'b110, 2'b10, 2'b00));
    tick(); tick();
    op = 6'b000001;
    tick(); tick(); check_vec("sub_exe", outs, v(3'b110, 6'b000000, 5'b00110, 3'b001, 2'b10, 2'b00));
    tick(); tick();
    op = 6'b000010;
    tick(); tick(); check_vec("addi_exe", outs, v(3'b110, 6'b000000, 5'b01110, 3'b000, 2'b01, 2'b00));
    tick(); tick(); check_vec("addi_ret", outs, V_IF);

    // sw completes normally
    op = 6'b110000;
    tick(); tick();
    tick(); check_vec("sw_mem", outs, v(3'b011, 6'b100010, 5'b01110, 3'b000, 2'b00, 2'b00));
    tick(); check_vec("sw_ret", outs, V_IF);

    // sw aborted by reset in MEM, before the next clock edge
    tick(); tick(); tick();
    check_vec("sw_mem2", outs, v(3'b011, 6'b100010, 5'b01110, 3'b000, 2'b00, 2'b00));
    #2 Reset = 1'b0;
    #1 check_vec("sw_abort", outs, V_IF);
    tick(); check_vec("reset_hold2", outs, V_IF);
    op = 6'b000000;
    Reset = 1'b1;
    tick(); check_vec("first_edge", outs, v(3'b001, 6'b000000, 5'b00110, 3'b000, 2'b10, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
